csa_add_sched: RTL and testbench

Scheduler that shares one combinational WIDTH-bit carry-select adder between two requesters. It arbitrates round-robin and accepts one request at a time. Each request is sequenced as a single pass (narrow) or two passes with carry chaining (wide, 2*WIDTH-bit). Results return on one shared response channel with backpressure. It sits between the ALU-side requesters and the shared adder instance.

---
 rtl/csa_add_sched_pkg.sv | 13 +
 rtl/csa_add_sched_rr_arb2.sv | 15 +
 rtl/csa_add_sched.sv | 125 ++++++++++++
 tb/tb_csa_add_sched.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/csa_add_sched_pkg.sv
// Shared constants and state type for the carry-select adder scheduler.
package csa_add_sched_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOW  = 2'd1,
    S_HIGH = 2'd2,
    S_RESP = 2'd3
  } state_t;

endpackage

// File: rtl/csa_add_sched_rr_arb2.sv
// Two-way round-robin arbiter: the requester that was not granted last wins a tie.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       enable,
  output logic [1:0] gnt
);

  always_comb begin
    gnt    = '0;
    gnt[0] = enable & req[0] & (~req[1] | last_grant);
    gnt[1] = enable & req[1] & (~req[0] | ~last_grant);
  end

endmodule

// File: rtl/csa_add_sched.sv
// Shares one external WIDTH-bit adder between two requesters, running narrow
// adds in one pass and wide adds in two carry-chained passes.
module csa_add_sched
  import csa_add_sched_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [1:0]           req_wide,
  input  logic [2*WIDTH-1:0]   req_a0,
  input  logic [2*WIDTH-1:0]   req_b0,
  input  logic                 req_cin0,
  input  logic [2*WIDTH-1:0]   req_a1,
  input  logic [2*WIDTH-1:0]   req_b1,
  input  logic                 req_cin1,
  output logic [WIDTH-1:0]     add_a,
  output logic [WIDTH-1:0]     add_b,
  output logic                 add_cin,
  input  logic [WIDTH-1:0]     add_sum,
  input  logic                 add_cout,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_id,
  output logic [2*WIDTH-1:0]   rsp_sum,
  output logic                 rsp_cout
);

  state_t state, state_nxt;

  logic [2*WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0]   sum_lo, sum_hi;
  logic               cin_q, wide_q, id_q, carry_q, last_grant;
  logic               idle;
  logic [1:0]         gnt;

  assign idle = (state == S_IDLE);

  rr_arb2 u_arb (
    .req        (req_valid),
    .last_grant (last_grant),
    .enable     (idle),
    .gnt        (gnt)
  );

  assign req_ready = gnt;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (|gnt) state_nxt = S_LOW;
      S_LOW:  state_nxt = wide_q ? S_HIGH : S_RESP;
      S_HIGH: state_nxt = S_RESP;
      S_RESP: if (rsp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    case (state)
      S_LOW: begin
        add_a   = a_q[WIDTH-1:0];
        add_b   = b_q[WIDTH-1:0];
        add_cin = cin_q;
      end
      S_HIGH: begin
        add_a   = a_q[2*WIDTH-1:WIDTH];
        add_b   = b_q[2*WIDTH-1:WIDTH];
        add_cin = carry_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      cin_q      <= 1'b0;
      wide_q     <= 1'b0;
      id_q       <= 1'b0;
      carry_q    <= 1'b0;
      sum_lo     <= '0;
      sum_hi     <= '0;
      last_grant <= 1'b1;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (|gnt) begin
            a_q    <= gnt[1] ? req_a1   : req_a0;
            b_q    <= gnt[1] ? req_b1   : req_b0;
            cin_q  <= gnt[1] ? req_cin1 : req_cin0;
            wide_q <= gnt[1] ? req_wide[1] : req_wide[0];
            id_q   <= gnt[1];
            // cleared here so a narrow result never shows a stale upper half
            sum_hi <= '0;
          end
        end
        S_LOW: begin
          sum_lo  <= add_sum;
          carry_q <= add_cout;
        end
        S_HIGH: begin
          sum_hi  <= add_sum;
          carry_q <= add_cout;
        end
        S_RESP: if (rsp_ready) last_grant <= id_q;
        default: ;
      endcase
    end
  end

  assign rsp_valid = (state == S_RESP);
  assign rsp_id    = id_q;
  assign rsp_sum   = {sum_hi, sum_lo};
  assign rsp_cout  = carry_q;

endmodule

// File: tb/tb_csa_add_sched.sv
// Self-checking bench: randomized and directed requests against an arithmetic
// reference model, with the shared adder modelled behaviourally.
module tb_csa_add_sched;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [1:0]     req_valid, req_ready, req_wide;
  logic [2*W-1:0] req_a0, req_b0, req_a1, req_b1;
  logic           req_cin0, req_cin1;
  logic [W-1:0]   add_a, add_b, add_sum;
  logic           add_cin, add_cout;
  logic           rsp_valid, rsp_ready, rsp_id, rsp_cout;
  logic [2*W-1:0] rsp_sum;

  int  checks = 0;
  int  errors = 0;
  logic model_last;

  always #5 clk = ~clk;

  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};

  csa_add_sched #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wide(req_wide),
    .req_a0(req_a0), .req_b0(req_b0), .req_cin0(req_cin0),
    .req_a1(req_a1), .req_b1(req_b1), .req_cin1(req_cin1),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_sum(rsp_sum), .rsp_cout(rsp_cout)
  );

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [2*W-1:0] rnd_op();
    case ($urandom_range(0, 4))
      0:       return '0;
      1:       return '1;
      2:       return {32'h0, 32'hFFFF_FFFF};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  task automatic run_txn(input logic [1:0] v, input logic [1:0] w,
                         input logic [2*W-1:0] a0, input logic [2*W-1:0] b0, input logic c0,
                         input logic [2*W-1:0] a1, input logic [2*W-1:0] b1, input logic c1,
                         input int bp);
    logic [1:0]     exp_g;
    logic           id, ec, ew, exp_cout;
    logic [2*W-1:0] ea, eb, exp_sum;
    logic [2*W:0]   full;
    int             lat;

    req_valid = v; req_wide = w;
    req_a0 = a0; req_b0 = b0; req_cin0 = c0;
    req_a1 = a1; req_b1 = b1; req_cin1 = c1;
    #1;
    exp_g = (v == 2'b11) ? (model_last ? 2'b01 : 2'b10) : v;
    check_eq("req_ready_grant", req_ready, exp_g);
    if (exp_g == 2'b00) return;

    id = exp_g[1];
    ea = id ? a1 : a0;
    eb = id ? b1 : b0;
    ec = id ? c1 : c0;
    ew = w[id];
    full = '0;
    if (ew) full = {1'b0, ea} + {1'b0, eb} + {{2*W{1'b0}}, ec};
    else    full[W:0] = {1'b0, ea[W-1:0]} + {1'b0, eb[W-1:0]} + {{W{1'b0}}, ec};
    exp_sum  = ew ? full[2*W-1:0] : {{W{1'b0}}, full[W-1:0]};
    exp_cout = ew ? full[2*W] : full[W];
    lat      = ew ? 2 : 1;

    @(posedge clk); @(negedge clk);
    req_a0 = ~a0; req_b0 = {$urandom, $urandom}; req_cin0 = ~c0;
    req_a1 = ~a1; req_b1 = {$urandom, $urandom}; req_cin1 = ~c1;
    req_wide = ~w;
    #1;
    check_eq("low_add_a", add_a, ea[W-1:0]);
    check_eq("low_add_cin", add_cin, ec);
    check_eq("busy_req_ready", req_ready, 2'b00);
    check_eq("early_rsp_valid", rsp_valid, 1'b0);
    for (int k = 1; k <= lat; k++) begin
      @(posedge clk); @(negedge clk); #1;
      check_eq("rsp_valid_latency", rsp_valid, (k == lat));
      check_eq("busy_req_ready", req_ready, 2'b00);
    end

    for (int k = 0; k < bp; k++) begin
      check_eq("hold_rsp_valid", rsp_valid, 1'b1);
      check_eq("hold_rsp_id", rsp_id, id);
      check_eq("hold_rsp_sum", rsp_sum, exp_sum);
      check_eq("hold_req_ready", req_ready, 2'b00);
      @(posedge clk); @(negedge clk); #1;
    end

    rsp_ready = 1'b1;
    check_eq("rsp_valid", rsp_valid, 1'b1);
    check_eq("rsp_id", rsp_id, id);
    check_eq("rsp_sum", rsp_sum, exp_sum);
    check_eq("rsp_cout", rsp_cout, exp_cout);
    @(posedge clk); @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 2'b00;
    model_last = id;
    #1;
    check_eq("rsp_valid_fall", rsp_valid, 1'b0);
    check_eq("idle_add_a", add_a, '0);
  endtask

  initial begin
    rst_n = 1'b0; rsp_ready = 1'b0;
    req_valid = '0; req_wide = '0;
    req_a0 = '0; req_b0 = '0; req_cin0 = 1'b0;
    req_a1 = '0; req_b1 = '0; req_cin1 = 1'b0;
    model_last = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check_eq("reset_rsp_valid", rsp_valid, 1'b0);
    check_eq("reset_rsp_id", rsp_id, 1'b0);
    check_eq("reset_rsp_sum", rsp_sum, '0);
    check_eq("reset_rsp_cout", rsp_cout, 1'b0);
    check_eq("reset_add_a", add_a, '0);
    rst_n = 1'b1;

    // idle with no requests
    repeat (3) begin
      @(posedge clk); @(negedge clk); #1;
      check_eq("idle_req_ready", req_ready, 2'b00);
      check_eq("idle_rsp_valid", rsp_valid, 1'b0);
    end

    // narrow carry-out, wide carry chain, wide wrap
    run_txn(2'b01, 2'b00, 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, '0, '0, 1'b0, 0);
    run_txn(2'b10, 2'b10, '0, '0, 1'b0, 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 0);
    run_txn(2'b01, 2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, '0, '0, 1'b0, 0);

    // arbitration from reset: 0,1,0,1
    rst_n = 1'b0; @(posedge clk); @(negedge clk); rst_n = 1'b1; model_last = 1'b1;
    for (int i = 0; i < 4; i++)
      run_txn(2'b11, 2'b00, rnd_op(), rnd_op(), 1'($urandom), rnd_op(), rnd_op(), 1'($urandom), 0);

    // backpressure
    run_txn(2'b10, 2'b11, rnd_op(), rnd_op(), 1'b0, rnd_op(), rnd_op(), 1'b1, 5);

    // reset while in HIGH
    req_valid = 2'b10; req_wide = 2'b10;
    req_a1 = '1; req_b1 = 64'd1; req_cin1 = 1'b0;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk); #1;
    check_eq("high_add_a", add_a, 32'hFFFF_FFFF);
    check_eq("high_add_cin", add_cin, 1'b1);
    rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1; req_valid = 2'b00; model_last = 1'b1;
    repeat (4) begin
      #1;
      check_eq("dropped_rsp_valid", rsp_valid, 1'b0);
      check_eq("dropped_rsp_sum", rsp_sum, '0);
      @(posedge clk); @(negedge clk);
    end
    run_txn(2'b11, 2'b00, rnd_op(), rnd_op(), 1'b1, rnd_op(), rnd_op(), 1'b0, 0);

    // randomized traffic
    for (int i = 0; i < 40; i++)
      run_txn(2'($urandom_range(1, 3)), 2'($urandom), rnd_op(), rnd_op(), 1'($urandom),
              rnd_op(), rnd_op(), 1'($urandom), int'($urandom_range(0, 3)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
